// File: rtl/if_pkg.sv
// Shared definitions for the MIPS instruction-fetch stage: FSM states,
// the bubble encoding and the default reset PC.
package if_pkg;

   typedef enum logic [1:0] {
      S_ISSUE = 2'd0,
      S_WAIT  = 2'd1,
      S_DROP  = 2'd2
   } fetchState_t;

   localparam logic [31:0] IF_NOP      = 32'h0000_0000;
   localparam logic [31:0] IF_RESET_PC = 32'h0040_0000;

   function automatic logic [31:0] pcPlus4(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/fetch_buffer.sv
// One-entry instruction holder (valid, word, PC) with fill, drain and flush.
// Used as the prefetch buffer or as the freeze-time pending register.
module fetch_buffer
   import if_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_fill,
   input  logic [31:0] i_fillWord,
   input  logic [31:0] i_fillPc,
   input  logic        i_drain,
   input  logic        i_flush,
   output logic        o_valid,
   output logic [31:0] o_word,
   output logic [31:0] o_pc
);

   logic        r_valid;
   logic [31:0] r_word;
   logic [31:0] r_pc;

   // Flush beats fill; a fill in the same cycle as a drain replaces the entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_word  <= IF_NOP;
         r_pc    <= 32'h0;
      end else if (i_flush) begin
         r_valid <= 1'b0;
      end else if (i_fill) begin
         r_valid <= 1'b1;
         r_word  <= i_fillWord;
         r_pc    <= i_fillPc;
      end else if (i_drain) begin
         r_valid <= 1'b0;
      end
   end

   assign o_valid = r_valid;
   assign o_word  = r_word;
   assign o_pc    = r_pc;

endmodule

// File: rtl/instr_fetch.sv
// MIPS instruction-fetch stage: single-outstanding IMEM requests, redirect
// squashing and freeze handling. Define IF_PREFETCH_EN to keep fetching during freeze.
module instr_fetch
   import if_pkg::*;
#(
   parameter logic [31:0] RESET_PC = IF_RESET_PC
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [31:0] Alt_PC_IN,
   input  logic        Request_Alt_PC_IN,
   input  logic        WANT_FREEZE_IN,
   output logic        IMEM_Req_OUT,
   output logic [31:0] IMEM_Addr_OUT,
   input  logic        IMEM_Ack_IN,
   input  logic [31:0] IMEM_Data_IN,
   output logic [31:0] Instr1_OUT,
   output logic [31:0] Instr_PC_OUT,
   output logic [31:0] Instr_PC_Plus4_OUT
);

   fetchState_t r_state;
   logic        r_req;
   logic [31:0] r_pc;
   logic [31:0] r_addr;
   logic [31:0] r_instr;
   logic [31:0] r_instrPc;
   logic [31:0] r_instrPcPlus4;

   logic        w_bufValid;
   logic [31:0] w_bufWord;
   logic [31:0] w_bufPc;
   logic        w_ackGood;
   logic        w_fill;
   logic        w_drain;
   logic        w_bufNextValid;
   logic        w_issueOk;
   logic [31:0] w_altPc;
   logic [31:0] w_pcNext;

   assign w_altPc   = Alt_PC_IN & 32'hFFFF_FFFC;
   assign w_ackGood = (r_state == S_WAIT) && IMEM_Ack_IN;

   // The held entry always goes to decode first, so a fresh ack only lands in
   // the holder when decode is frozen or is busy draining the older entry.
   assign w_drain        = !WANT_FREEZE_IN && w_bufValid;
   assign w_fill         = w_ackGood && !Request_Alt_PC_IN && (WANT_FREEZE_IN || w_bufValid);
   assign w_bufNextValid = !Request_Alt_PC_IN && (w_fill || (w_bufValid && !w_drain));

   assign w_pcNext = Request_Alt_PC_IN ? w_altPc :
                     (w_ackGood ? pcPlus4(r_pc) : r_pc);

`ifdef IF_PREFETCH_EN
   assign w_issueOk = !(WANT_FREEZE_IN && w_bufNextValid);

   fetch_buffer u_prefetch (
      .clk        (CLK),
      .rst_n      (RESET),
      .i_fill     (w_fill),
      .i_fillWord (IMEM_Data_IN),
      .i_fillPc   (r_addr),
      .i_drain    (w_drain),
      .i_flush    (Request_Alt_PC_IN),
      .o_valid    (w_bufValid),
      .o_word     (w_bufWord),
      .o_pc       (w_bufPc)
   );
`else
   assign w_issueOk = !WANT_FREEZE_IN && !w_bufNextValid;

   fetch_buffer u_pend (
      .clk        (CLK),
      .rst_n      (RESET),
      .i_fill     (w_fill),
      .i_fillWord (IMEM_Data_IN),
      .i_fillPc   (r_addr),
      .i_drain    (w_drain),
      .i_flush    (Request_Alt_PC_IN),
      .o_valid    (w_bufValid),
      .o_word     (w_bufWord),
      .o_pc       (w_bufPc)
   );
`endif

   // r_addr is frozen while a request is live; in S_DROP it still names the
   // squashed address while r_pc already holds the redirect target.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_state <= S_ISSUE;
         r_pc    <= RESET_PC;
         r_req   <= 1'b0;
         r_addr  <= RESET_PC;
      end else begin
         r_pc <= w_pcNext;
         case (r_state)
            S_ISSUE: begin
               r_addr <= w_pcNext;
               if (w_issueOk) begin
                  r_req   <= 1'b1;
                  r_state <= S_WAIT;
               end else begin
                  r_req <= 1'b0;
               end
            end
            S_WAIT: begin
               if (IMEM_Ack_IN) begin
                  r_addr  <= w_pcNext;
                  r_req   <= w_issueOk;
                  r_state <= w_issueOk ? S_WAIT : S_ISSUE;
               end else if (Request_Alt_PC_IN) begin
                  r_state <= S_DROP;
               end
            end
            S_DROP: begin
               if (IMEM_Ack_IN) begin
                  r_addr  <= w_pcNext;
                  r_req   <= 1'b0;
                  r_state <= S_ISSUE;
               end
            end
            default: begin
               r_req   <= 1'b0;
               r_state <= S_ISSUE;
            end
         endcase
      end
   end

   // A word acked alongside a redirect is the delay slot and still reaches decode.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_instr        <= IF_NOP;
         r_instrPc      <= 32'h0;
         r_instrPcPlus4 <= 32'h0;
      end else if (!WANT_FREEZE_IN) begin
         if (w_bufValid) begin
            r_instr        <= w_bufWord;
            r_instrPc      <= w_bufPc;
            r_instrPcPlus4 <= pcPlus4(w_bufPc);
         end else if (w_ackGood) begin
            r_instr        <= IMEM_Data_IN;
            r_instrPc      <= r_addr;
            r_instrPcPlus4 <= pcPlus4(r_addr);
         end else begin
            r_instr <= IF_NOP;
         end
      end
   end

   assign IMEM_Req_OUT       = r_req;
   assign IMEM_Addr_OUT      = r_addr;
   assign Instr1_OUT         = r_instr;
   assign Instr_PC_OUT       = r_instrPc;
   assign Instr_PC_Plus4_OUT = r_instrPcPlus4;

endmodule
